// File: rtl/binary_blitz_round.sv
`default_nettype none
// ============================================================================
// Module   : binary_blitz_round
// Purpose  : Round controller for the binary-guessing game. Generates a
//            pseudo-random WIDTH-bit target from a Fibonacci LFSR, runs a
//            per-round seconds countdown, judges the player's answer when the
//            countdown expires, keeps score over ROUNDS rounds and drives a
//            square-wave correct/wrong tone on the speaker.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - one-cycle pulse, begins/restarts a game
//            answer          - player switch value (sampled in JUDGE only)
//            target          - current round target (0 when idle)
//            sec_left        - seconds remaining in the round
//            round_num       - current round 1..ROUNDS (0 when idle)
//            score           - correct answers this game
//            hit / miss      - one-cycle judgement pulses
//            speaker         - tone output
//            busy / done     - game in progress / game finished
// Options  : BLITZ_EARLY_SUBMIT_EN - when defined, a correct answer seen at
//            any cycle of SHOW ends the countdown early and scores a hit.
// Revision : 1.0 - initial release
// ============================================================================
module binary_blitz_round #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned COUNT_SEC   = 3,
  parameter int unsigned ROUNDS      = 8,
  parameter int unsigned TICK_DIV    = 10000000,
  parameter int unsigned TONE_LEN    = 2000000,
  parameter int unsigned TONE_HI_DIV = 9551,
  parameter int unsigned TONE_LO_DIV = 14327
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] answer,
  output logic [WIDTH-1:0] target,
  output logic [3:0]       sec_left,
  output logic [3:0]       round_num,
  output logic [3:0]       score,
  output logic             hit,
  output logic             miss,
  output logic             speaker,
  output logic             busy,
  output logic             done
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TONE_W  = (TONE_LEN > 1) ? $clog2(TONE_LEN) : 1;
  localparam int DIV_MAX = (TONE_HI_DIV > TONE_LO_DIV) ? TONE_HI_DIV : TONE_LO_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_LEN - 1);
  localparam logic [DIV_W-1:0]  HI_LAST   = DIV_W'(TONE_HI_DIV - 1);
  localparam logic [DIV_W-1:0]  LO_LAST   = DIV_W'(TONE_LO_DIV - 1);
  localparam logic [3:0]        SEC_INIT  = 4'(COUNT_SEC);
  localparam logic [3:0]        LAST_RND  = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_JUDGE = 3'd2,
    S_TONE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   lfsr_q,     lfsr_d;
  logic [WIDTH-1:0]   target_q,   target_d;
  logic [3:0]         sec_q,      sec_d;
  logic [3:0]         round_q,    round_d;
  logic [3:0]         score_q,    score_d;
  logic               hit_q,      hit_d;
  logic               miss_q,     miss_d;
  logic               spk_q,      spk_d;
  logic [TICK_W-1:0]  tick_q,     tick_d;
  logic [TONE_W-1:0]  tone_q,     tone_d;
  logic [DIV_W-1:0]   div_q,      div_d;
  logic               tone_hi_q,  tone_hi_d;   // selects the correct-answer tone
  logic               early_q,    early_d;     // round ended by early submit

  // --------------------------------------------------------------------------
  // LFSR feedback: XOR of the maximal-length taps for the chosen width.
  // --------------------------------------------------------------------------
  logic             lfsr_fb;
  logic [WIDTH-1:0] lfsr_next;

  generate
    if (WIDTH == 4) begin : g_taps_w4
      assign lfsr_fb = lfsr_q[3] ^ lfsr_q[2];
    end else if (WIDTH == 5) begin : g_taps_w5
      assign lfsr_fb = lfsr_q[4] ^ lfsr_q[2];
    end else if (WIDTH == 6) begin : g_taps_w6
      assign lfsr_fb = lfsr_q[5] ^ lfsr_q[4];
    end else if (WIDTH == 7) begin : g_taps_w7
      assign lfsr_fb = lfsr_q[6] ^ lfsr_q[5];
    end else begin : g_taps_w8
      assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end
  endgenerate

  assign lfsr_next = {lfsr_q[WIDTH-2:0], lfsr_fb};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    target_d  = target_q;
    sec_d     = sec_q;
    round_d   = round_q;
    score_d   = score_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    spk_d     = spk_q;
    tick_d    = tick_q;
    tone_d    = tone_q;
    div_d     = div_q;
    tone_hi_d = tone_hi_q;
    early_d   = early_q;

    // The target is frozen while the player is looking at it, so the LFSR
    // only advances outside SHOW and JUDGE.
    if ((state_q == S_IDLE) || (state_q == S_TONE) || (state_q == S_DONE)) begin
      lfsr_d = lfsr_next;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHOW;
          round_d  = 4'd1;
          score_d  = 4'd0;
          target_d = lfsr_q;
          sec_d    = SEC_INIT;
          tick_d   = '0;
          early_d  = 1'b0;
        end
      end

      S_SHOW: begin
`ifdef BLITZ_EARLY_SUBMIT_EN
        if (answer == target_q) begin
          // Countdown freezes; the judgement is forced to a hit.
          state_d = S_JUDGE;
          early_d = 1'b1;
        end else
`endif
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          sec_d  = sec_q - 4'd1;
          if (sec_q == 4'd1) begin
            state_d = S_JUDGE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_JUDGE: begin
        if (early_q || (answer == target_q)) begin
          hit_d     = 1'b1;
          tone_hi_d = 1'b1;
          if (score_q != 4'hF) begin
            score_d = score_q + 4'd1;
          end
        end else begin
          miss_d    = 1'b1;
          tone_hi_d = 1'b0;
        end
        early_d = 1'b0;
        state_d = S_TONE;
        tone_d  = '0;
        div_d   = '0;
        spk_d   = 1'b0;
      end

      S_TONE: begin
        if (tone_q == TONE_LAST) begin
          spk_d  = 1'b0;
          tone_d = '0;
          div_d  = '0;
          if (round_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SHOW;
            round_d  = round_q + 4'd1;
            target_d = lfsr_q;
            sec_d    = SEC_INIT;
            tick_d   = '0;
          end
        end else begin
          tone_d = tone_q + 1'b1;
          if (div_q == (tone_hi_q ? HI_LAST : LO_LAST)) begin
            div_d = '0;
            spk_d = ~spk_q;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= WIDTH'(1);
      target_q  <= '0;
      sec_q     <= 4'd0;
      round_q   <= 4'd0;
      score_q   <= 4'd0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      spk_q     <= 1'b0;
      tick_q    <= '0;
      tone_q    <= '0;
      div_q     <= '0;
      tone_hi_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      sec_q     <= sec_d;
      round_q   <= round_d;
      score_q   <= score_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      spk_q     <= spk_d;
      tick_q    <= tick_d;
      tone_q    <= tone_d;
      div_q     <= div_d;
      tone_hi_q <= tone_hi_d;
      early_q   <= early_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign target    = target_q;
  assign sec_left  = sec_q;
  assign round_num = round_q;
  assign score     = score_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign speaker   = spk_q;
  assign busy      = (state_q == S_SHOW) || (state_q == S_JUDGE) || (state_q == S_TONE);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_binary_blitz_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_blitz_round
// Purpose  : Self-checking bench for binary_blitz_round. A directed game is
//            checked against a table of expected outputs at chosen cycles,
//            and every cycle (directed and random) is checked against a
//            behavioural model of the game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_blitz_round;

  localparam int W  = 4;
  localparam int CS = 3;
  localparam int RN = 2;
  localparam int TD = 10;
  localparam int TL = 20;
  localparam int HD = 2;
  localparam int LD = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] answer = '0;
  logic [W-1:0] target;
  logic [3:0]   sec_left, round_num, score;
  logic         hit, miss, speaker, busy, done;

  always #5 clk = ~clk;

  binary_blitz_round #(
    .WIDTH(W), .COUNT_SEC(CS), .ROUNDS(RN), .TICK_DIV(TD),
    .TONE_LEN(TL), .TONE_HI_DIV(HD), .TONE_LO_DIV(LD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .answer(answer),
    .target(target), .sec_left(sec_left), .round_num(round_num),
    .score(score), .hit(hit), .miss(miss), .speaker(speaker),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // --------------------------------------------------------------------------
  // Behavioural model: game phase plus elapsed-time counts, values derived
  // arithmetically from the rules.
  // --------------------------------------------------------------------------
  localparam int P_IDLE = 0, P_SHOW = 1, P_JUDGE = 2, P_TONE = 3, P_DONE = 4;

  int         m_phase, m_elapsed, m_t, m_div;
  logic [3:0] m_lfsr, m_tgt, m_sec, m_rnd, m_scr;
  logic       m_hit, m_miss, m_spk, m_early;

  always @(posedge clk) begin : p_model
    logic [3:0] nxt;
    nxt = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    if (rst) begin
      m_phase = P_IDLE; m_lfsr = 4'd1; m_tgt = 0; m_sec = 0; m_rnd = 0;
      m_scr = 0; m_hit = 0; m_miss = 0; m_spk = 0; m_early = 0;
      m_elapsed = 0; m_t = 0; m_div = LD;
    end else begin
      m_hit  = 0;
      m_miss = 0;
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start) begin
            m_phase = P_SHOW; m_rnd = 1; m_scr = 0; m_tgt = m_lfsr;
            m_sec = 4'(CS); m_elapsed = 0; m_early = 0;
          end
          m_lfsr = nxt;
        end
        P_SHOW: begin
`ifdef BLITZ_EARLY_SUBMIT_EN
          if (answer == m_tgt) begin
            m_phase = P_JUDGE;
            m_early = 1;
          end else
`endif
          begin
            m_elapsed++;
            m_sec = 4'(CS - m_elapsed / TD);
            if (m_elapsed == CS * TD) m_phase = P_JUDGE;
          end
        end
        P_JUDGE: begin
          if (m_early || answer == m_tgt) begin
            m_hit = 1; m_div = HD;
            if (m_scr != 4'hF) m_scr++;
          end else begin
            m_miss = 1; m_div = LD;
          end
          m_early = 0; m_t = 0; m_spk = 0; m_phase = P_TONE;
        end
        default: begin // P_TONE
          if (m_t == TL - 1) begin
            m_spk = 0;
            if (m_rnd == 4'(RN)) m_phase = P_DONE;
            else begin
              m_phase = P_SHOW; m_rnd++; m_tgt = m_lfsr;
              m_sec = 4'(CS); m_elapsed = 0;
            end
          end else begin
            m_t++;
            m_spk = ((m_t / m_div) % 2) == 1;
          end
          m_lfsr = nxt;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Comparison helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_model();
    chk("model_target",    8'(target),    8'(m_tgt));
    chk("model_sec_left",  8'(sec_left),  8'(m_sec));
    chk("model_round_num", 8'(round_num), 8'(m_rnd));
    chk("model_score",     8'(score),     8'(m_scr));
    chk("model_hit",       8'(hit),       8'(m_hit));
    chk("model_miss",      8'(miss),      8'(m_miss));
    chk("model_speaker",   8'(speaker),   8'(m_spk));
    chk("model_busy",      8'(busy),      8'(m_phase == P_SHOW || m_phase == P_JUDGE || m_phase == P_TONE));
    chk("model_done",      8'(done),      8'(m_phase == P_DONE));
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] tgt, sec, rnd, scr;
    logic       hit, miss, spk, busy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic check_row(input vec_t r);
    chk("row_target",    8'(target),    8'(r.tgt));
    chk("row_sec_left",  8'(sec_left),  8'(r.sec));
    chk("row_round_num", 8'(round_num), 8'(r.rnd));
    chk("row_score",     8'(score),     8'(r.scr));
    chk("row_hit",       8'(hit),       8'(r.hit));
    chk("row_miss",      8'(miss),      8'(r.miss));
    chk("row_speaker",   8'(speaker),   8'(r.spk));
    chk("row_busy",      8'(busy),      8'(r.busy));
    chk("row_done",      8'(done),      8'(r.done));
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : p_main
    int idx;
    int last_c;
    idx = 0;

    // Expected outputs at chosen cycles: cyc, target, sec, round, score,
    // hit, miss, speaker, busy, done.
`ifndef BLITZ_EARLY_SUBMIT_EN
    last_c = 129;
    tbl.push_back(vec_t'{  1, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{  2, 4'h1, 4'd3, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 11, 4'h1, 4'd3, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 12, 4'h1, 4'd2, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 16, 4'h1, 4'd2, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 22, 4'h1, 4'd1, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 31, 4'h1, 4'd1, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 32, 4'h1, 4'd0, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 33, 4'h1, 4'd0, 4'd1, 4'd1, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 34, 4'h1, 4'd0, 4'd1, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 35, 4'h1, 4'd0, 4'd1, 4'd1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{ 37, 4'h1, 4'd0, 4'd1, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 41, 4'h1, 4'd0, 4'd1, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 52, 4'h1, 4'd0, 4'd1, 4'd1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{ 53, 4'h6, 4'd3, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 63, 4'h6, 4'd2, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 83, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 84, 4'h6, 4'd0, 4'd2, 4'd1, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{ 85, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 88, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{ 89, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{ 94, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{103, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{104, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, 1});
    tbl.push_back(vec_t'{110, 4'h6, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, 1});
    tbl.push_back(vec_t'{111, 4'h4, 4'd3, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{126, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{128, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{129, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
`else
    last_c = 9;
    tbl.push_back(vec_t'{  1, 4'h0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{  5, 4'h1, 4'd3, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{  6, 4'h1, 4'd3, 4'd1, 4'd0, 0, 0, 0, 1, 0});
    tbl.push_back(vec_t'{  7, 4'h1, 4'd3, 4'd1, 4'd1, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{  8, 4'h1, 4'd3, 4'd1, 4'd1, 0, 0, 0, 1, 0});
`endif

    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed game: inputs for edge c, outputs observed in cycle c+1.
    for (int c = 0; c <= last_c; c++) begin
`ifndef BLITZ_EARLY_SUBMIT_EN
      rst    = (c == 0) || (c == 125) || (c == 127);
      start  = (c == 1) || (c == 15) || (c == 40) || (c == 110) || (c == 127);
      answer = (c <= 52) ? 4'h1 : 4'h0;
`else
      rst    = (c == 0);
      start  = (c == 1);
      answer = (c >= 5) ? 4'h1 : 4'h0;
`endif
      @(negedge clk);
      cyc = c + 1;
      check_model();
      if (idx < tbl.size() && tbl[idx].cyc == cyc) begin
        check_row(tbl[idx]);
        idx++;
      end
    end

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 399) == 0);
      start  = ($urandom_range(0, 15) == 0);
      answer = ($urandom_range(0, 1) == 1) ? m_tgt : 4'($urandom);
      @(negedge clk);
      cyc++;
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
